// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer.
// Widths, FSM state encoding and the fetch-queue entry layout.
package fetch_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch bus: imem req/gnt/rvalid port plus the decode valid/ready port.
// master is the fetch sequencer, slave is the memory/decode side.
interface fetch_ctrl_if;
    import fetch_pkg::*;

    logic               imem_req_o;
    logic [ADDR_W-1:0]  imem_addr_o;
    logic               imem_gnt_i;
    logic               imem_rvalid_i;
    logic [INSTR_W-1:0] imem_rdata_i;

    logic               instr_valid_o;
    logic [INSTR_W-1:0] instr_o;
    logic [ADDR_W-1:0]  instr_pc_o;
    logic               instr_ready_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output instr_valid_o, instr_o, instr_pc_o,
        input  instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  instr_valid_o, instr_o, instr_pc_o,
        output instr_ready_i
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched words; flush beats both push and pop.
// Storage is reset so the head reads zero out of reset.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  fetch_entry_t                 data_i,
    output fetch_entry_t                 data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= inc(wr_q);
            end
            if (do_pop) rd_q <= inc(rd_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem request at a time and
// buffers responses for decode; redirects flush and squash stale fetches.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_address_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branchloc_i,
    input  logic              halt_i,
    output logic              busy_o,
    fetch_ctrl_if.master      bus
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              squash_q, squash_d;
    logic              halt_q, halt_d;

    logic              redirect;
    logic              gnt_ok;
    logic              rsp;
    logic              outstanding;
    logic              halt_eff;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    fetch_entry_t      rsp_entry;
    fetch_entry_t      head;

    assign bus.imem_req_o  = (state_q == REQ) & (count < CW'(QDEPTH));
    assign bus.imem_addr_o = pc_q;

    assign gnt_ok   = bus.imem_req_o & bus.imem_gnt_i;
    assign rsp      = (state_q == WAIT) & bus.imem_rvalid_i;
    assign redirect = start_i | (branch_i & (state_q != IDLE));
    assign halt_eff = halt_i | halt_q;
    assign push     = rsp & ~squash_q;
    assign pop      = bus.instr_valid_o & bus.instr_ready_i;

    // A request still owed a response after this edge must be squashed.
    assign outstanding = gnt_ok | ((state_q == WAIT) & ~bus.imem_rvalid_i);

    // pc has already advanced past the outstanding request.
    assign rsp_entry = '{addr: pc_q - 1'b1, instr: bus.imem_rdata_i};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        squash_d = squash_q;
        halt_d   = halt_q;
        if (redirect) begin
            pc_d     = start_i ? start_address_i : branchloc_i;
            halt_d   = halt_q & ~start_i;
            squash_d = outstanding;
            state_d  = outstanding ? WAIT : REQ;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                REQ: begin
                    if (gnt_ok) begin
                        pc_d    = pc_q + 1'b1;
                        state_d = WAIT;
                    end else if (halt_eff) begin
                        state_d = IDLE;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid_i) begin
                        squash_d = 1'b0;
                        state_d  = halt_eff ? IDLE : REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
            halt_d = halt_eff & (state_q != IDLE) & (state_d != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            squash_q <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            squash_q <= squash_d;
            halt_q   <= halt_d;
        end
    end

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk     (clk),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .data_i  (rsp_entry),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst_i)
        (push && !redirect) |-> !full
    );

    assign bus.instr_valid_o = ~empty;
    assign bus.instr_o       = head.instr;
    assign bus.instr_pc_o    = head.addr;
    assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a one-outstanding imem responder
// and a log of every word decode consumes.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [ADDR_W-1:0] start_address_i;
    logic              branch_i;
    logic [ADDR_W-1:0] branchloc_i;
    logic              halt_i;
    logic              busy_o;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.QDEPTH(2)) dut (
        .clk             (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .start_address_i (start_address_i),
        .branch_i        (branch_i),
        .branchloc_i     (branchloc_i),
        .halt_i          (halt_i),
        .busy_o          (busy_o),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int                n_chk  = 0;
    int                n_fail = 0;
    logic              stall;
    logic              pend;
    logic [ADDR_W-1:0] pend_a;
    logic [ADDR_W-1:0] got [$];

    function automatic logic [INSTR_W-1:0] word(input logic [ADDR_W-1:0] a);
        return {a ^ 8'h5A, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pc_at(input int i);
        return (i < got.size()) ? 32'(got[i]) : 32'hDEAD;
    endfunction

    // One clock: log the consume seen at this edge, then drive imem.
    task automatic tick();
        if (!rst_i && bus.instr_valid_o && bus.instr_ready_i &&
            !(start_i || (branch_i && busy_o))) begin
            got.push_back(bus.instr_pc_o);
            chk("word", 32'(bus.instr_o), 32'(word(bus.instr_pc_o)));
        end
        @(posedge clk);
        #1;
        if (stall) begin
            bus.imem_rvalid_i = 1'b0;
        end else begin
            bus.imem_rvalid_i = pend;
            pend = 1'b0;
        end
        bus.imem_rdata_i = bus.imem_rvalid_i ? word(pend_a) : '0;
        bus.imem_gnt_i   = bus.imem_req_o;
        if (bus.imem_req_o) begin
            pend   = 1'b1;
            pend_a = bus.imem_addr_o;
        end
    endtask

    task automatic wait_got(input string tag, input int n);
        int k = 0;
        while (got.size() < n && k < 60) begin
            tick();
            k++;
        end
        chk(tag, 32'(got.size() >= n), 32'd1);
    endtask

    task automatic wait_req(input string tag);
        int k = 0;
        while (!bus.imem_req_o && k < 20) begin
            tick();
            k++;
        end
        chk(tag, 32'(bus.imem_req_o), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"},   32'(bus.imem_req_o),    32'd0);
        chk({tag, "_addr"},  32'(bus.imem_addr_o),   32'd0);
        chk({tag, "_valid"}, 32'(bus.instr_valid_o), 32'd0);
        chk({tag, "_instr"}, 32'(bus.instr_o),       32'd0);
        chk({tag, "_pc"},    32'(bus.instr_pc_o),    32'd0);
        chk({tag, "_busy"},  32'(busy_o),            32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        branch_i = 1'b0;
        halt_i = 1'b0;
        start_address_i = '0;
        branchloc_i = '0;
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = '0;
        bus.instr_ready_i = 1'b0;
        stall = 1'b0;
        pend = 1'b0;
        pend_a = '0;
        tick();
        tick();
        chk_zero("rst");

        // stream from 0x10, latency start->valid is three edges
        rst_i = 1'b0;
        bus.instr_ready_i = 1'b1;
        start_i = 1'b1;
        start_address_i = 8'h10;
        tick();
        start_i = 1'b0;
        chk("t1_req", 32'(bus.imem_req_o), 32'd1);
        chk("t1_addr", 32'(bus.imem_addr_o), 32'h10);
        tick();
        chk("t1_lat2", 32'(bus.instr_valid_o), 32'd0);
        tick();
        chk("t1_lat3", 32'(bus.instr_valid_o), 32'd1);
        chk("t1_head", 32'(bus.instr_pc_o), 32'h10);
        wait_got("t1_cnt", 4);
        for (int i = 0; i < 4; i++) chk("t1_pc", pc_at(i), 32'h10 + i);

        // decode stalled: two words queued, no further requests
        got.delete();
        bus.instr_ready_i = 1'b0;
        start_i = 1'b1;
        start_address_i = 8'h10;
        tick();
        start_i = 1'b0;
        repeat (10) tick();
        chk("t2_valid", 32'(bus.instr_valid_o), 32'd1);
        chk("t2_head", 32'(bus.instr_pc_o), 32'h10);
        chk("t2_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_noreq", 32'(bus.imem_req_o), 32'd0);
        end
        bus.instr_ready_i = 1'b1;
        tick();
        chk("t2_resume", 32'(bus.imem_req_o), 32'd1);
        chk("t2_raddr", 32'(bus.imem_addr_o), 32'h12);
        wait_got("t2_cnt", 3);
        for (int i = 0; i < 3; i++) chk("t2_pc", pc_at(i), 32'h10 + i);

        // wrap 0xFF -> 0x00
        got.delete();
        start_i = 1'b1;
        start_address_i = 8'hFE;
        tick();
        start_i = 1'b0;
        wait_got("t3_cnt", 3);
        chk("t3_pc0", pc_at(0), 32'hFE);
        chk("t3_pc1", pc_at(1), 32'hFF);
        chk("t3_pc2", pc_at(2), 32'h00);

        // branch while the 0x13 response is outstanding
        start_i = 1'b1;
        start_address_i = 8'h10;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 40 && !(pend && pend_a == 8'h13); k++) tick();
        chk("t4_reach", 32'(pend && pend_a == 8'h13), 32'd1);
        stall = 1'b1;
        tick();
        chk("t4_wait", 32'(busy_o && !bus.imem_req_o), 32'd1);
        got.delete();
        branch_i = 1'b1;
        branchloc_i = 8'h40;
        tick();
        branch_i = 1'b0;
        stall = 1'b0;
        chk("t4_hold", 32'(bus.imem_req_o), 32'd0);
        wait_got("t4_cnt", 2);
        chk("t4_pc0", pc_at(0), 32'h40);
        chk("t4_pc1", pc_at(1), 32'h41);

        // start beats branch in the same cycle
        got.delete();
        start_i = 1'b1;
        start_address_i = 8'h80;
        branch_i = 1'b1;
        branchloc_i = 8'h55;
        tick();
        start_i = 1'b0;
        branch_i = 1'b0;
        wait_got("t5a_cnt", 2);
        chk("t5a_pc0", pc_at(0), 32'h80);
        chk("t5a_pc1", pc_at(1), 32'h81);

        // branch coincident with a grant: granted word is squashed
        wait_req("t5b_req");
        got.delete();
        branch_i = 1'b1;
        branchloc_i = 8'h60;
        tick();
        branch_i = 1'b0;
        chk("t5b_wait", 32'(busy_o && !bus.imem_req_o), 32'd1);
        wait_got("t5b_cnt", 2);
        chk("t5b_pc0", pc_at(0), 32'h60);
        chk("t5b_pc1", pc_at(1), 32'h61);

        // halt in WAIT: response still queued, then IDLE
        rst_i = 1'b1;
        bus.instr_ready_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        got.delete();
        start_i = 1'b1;
        start_address_i = 8'h20;
        tick();
        start_i = 1'b0;
        stall = 1'b1;
        tick();
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        stall = 1'b0;
        tick();
        chk("t6_latched", 32'(busy_o), 32'd1);
        tick();
        chk("t6_busy", 32'(busy_o), 32'd0);
        chk("t6_valid", 32'(bus.instr_valid_o), 32'd1);
        chk("t6_head", 32'(bus.instr_pc_o), 32'h20);
        chk("t6_instr", 32'(bus.instr_o), 32'(word(8'h20)));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_noreq", 32'(bus.imem_req_o), 32'd0);
        end
        bus.instr_ready_i = 1'b1;
        tick();
        chk("t6_drain", 32'(bus.instr_valid_o), 32'd0);
        chk("t6_pc", pc_at(0), 32'h20);

        // reset mid-fetch; the late response must be ignored
        start_i = 1'b1;
        start_address_i = 8'h30;
        tick();
        start_i = 1'b0;
        stall = 1'b1;
        tick();
        chk("t7_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        tick();
        chk_zero("t7_rst");
        rst_i = 1'b0;
        stall = 1'b0;
        tick();
        chk("t7_late", 32'(bus.imem_rvalid_i), 32'd1);
        tick();
        chk("t7_valid", 32'(bus.instr_valid_o), 32'd0);
        chk("t7_idle", 32'(busy_o), 32'd0);
        chk("t7_noreq", 32'(bus.imem_req_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
